uart_tx_frame: RTL and testbench
================================

UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001: Clock  in  1  single system clock; all state updates on rising edge.
REQ-002: Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clock.
REQ-003: BaudTick  in  1  one-Clock-cycle pulse marking the end of each bit period.
REQ-004: Send  in  1  request to transmit one frame; sampled only while idle.
REQ-005: DataIn  in  8  payload byte, captured on accepted Send.
REQ-006: ParityType  in  2  01 = odd, 10 = even, 00/11 = no parity; captured on accepted Send.
REQ-007: StopBits  in  1  0 = one stop bit, 1 = two stop bits; captured on accepted Send.
REQ-008: DataTx  out  1  serial line, idle high.
REQ-009: Busy  out  1  high from the cycle after Send is accepted until the frame completes.
REQ-010: Done  out  1  one-cycle pulse when the last stop bit period ends.

Function
REQ-011: Frame order SHALL be start (0), DataIn[0] through DataIn[7] (LSB first), optional parity, then one or two stop bits (1).
REQ-012: FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013: In IDLE with Send=1, the block SHALL capture DataIn, ParityType and StopBits, and enter START on the next edge.
REQ-014: Send SHALL be ignored in every state except IDLE; captured values SHALL NOT change mid-frame.
REQ-015: DataTx SHALL be a registered output equal to the current state's bit: START 0, DATA current data bit, PARITY parity bit, STOP/IDLE 1.
REQ-016: Each non-IDLE state (or bit within DATA/STOP) SHALL end on the edge where BaudTick=1; the next bit is driven from the following cycle.
REQ-017: BaudTick while IDLE SHALL have no effect.
REQ-018: DATA SHALL use a 3-bit bit index, 0 to 7; it leaves DATA on the BaudTick at index 7.
REQ-019: After DATA, the FSM SHALL enter PARITY when the captured ParityType is 01 or 10, else STOP.
REQ-020: The odd-parity bit SHALL be the inverted XOR of the captured byte; the even-parity bit SHALL be the XOR of the byte. The total count of ones in data plus parity is then odd or even, matching the receive-side check.
REQ-021: STOP SHALL last one bit period, or two when captured StopBits=1, using a 1-bit stop counter.
REQ-022: On the BaudTick ending the final stop bit, the FSM SHALL return to IDLE; Done SHALL be 1 and Busy 0 in the cycle that follows.
REQ-023: A Send asserted in the Done cycle SHALL be accepted, giving back-to-back frames with no idle bit period.
REQ-024: Busy SHALL equal 1 exactly while the state is not IDLE.
REQ-025: Frame length in BaudTicks SHALL be 10 (no parity, 1 stop) to 12 (parity, 2 stops).

Reset
REQ-026: Reset SHALL take priority over all other inputs in any state, including mid-frame.
REQ-027: In the cycle after Reset, the outputs SHALL be DataTx=1, Busy=0 and Done=0, with state IDLE and all counters and captured registers at 0.
REQ-028: A frame interrupted by Reset SHALL NOT resume and SHALL NOT pulse Done.

Structure
REQ-029: The shared package uart_pkg SHALL hold the ParityType encodings (ODD=2'b01, EVEN=2'b10, NOPAR1=2'b00, NOPAR2=2'b11) and the FSM state enum. The receive side shares the same encodings.
REQ-030: One combinational sub-module, parity_gen, SHALL map the captured byte and ParityType to the parity bit.
REQ-031: The top level SHALL contain the FSM, the data shift register or index mux, the bit index counter and the stop counter.

Verification
REQ-032: DataIn=8'hA5, ParityType=01, StopBits=0, BaudTick every 16 cycles -> DataTx per period 0,1,0,1,0,0,1,0,1,1(parity),1; Done once after the 11th tick.
REQ-033: DataIn=8'h07, ParityType=10, StopBits=1 -> parity bit 1, two stop bits, 12 ticks; Busy high for the whole frame.
REQ-034: DataIn=8'h3C, ParityType=00 and then 11 -> no parity bit, 10-tick frame in both cases.
REQ-035: Send held high through the frame with DataIn changed mid-frame -> first byte sent unchanged; the second frame starts immediately after the Done cycle with the new byte.
REQ-036: Reset asserted during DATA bit 4 -> next cycle DataTx=1, Busy=0, Done never pulses; a subsequent Send gives a correct full frame.
REQ-037: BaudTick pulses while IDLE with Send=0 -> DataTx stays 1 and Busy/Done stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- encodings shared by the UART transmit and receive sides.
//   ODD/EVEN/NOPAR1/NOPAR2 : ParityType field encodings
//   state_e                : transmit framer FSM states
//   has_parity()           : true when a ParityType selects a parity bit
package uart_pkg;

   localparam logic [1:0] NOPAR1 = 2'b00;
   localparam logic [1:0] ODD    = 2'b01;
   localparam logic [1:0] EVEN   = 2'b10;
   localparam logic [1:0] NOPAR2 = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   function automatic logic has_parity(input logic [1:0] par_type);
      return (par_type == ODD) || (par_type == EVEN);
   endfunction

endpackage

// File: rtl/parity_gen.sv
// parity_gen -- combinational parity bit for one captured byte.
//   data       : captured payload byte
//   par_type   : captured ParityType (ODD / EVEN / no parity)
//   parity_bit : bit that makes data+parity odd (ODD) or even (EVEN); 0 otherwise
module parity_gen
   import uart_pkg::*;
(
   input  logic [7:0] data,
   input  logic [1:0] par_type,
   output logic       parity_bit
);

   always_comb begin
      parity_bit = 1'b0;
      case (par_type)
         EVEN:    parity_bit = ^data;
         ODD:     parity_bit = ~^data;
         default: parity_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmit framer: start, 8 data bits LSB first,
// optional parity, one or two stop bits, advanced by an external BaudTick.
//   Clock, Reset : system clock, synchronous active-high reset
//   BaudTick     : one-cycle pulse ending each bit period
//   Send         : frame request, only looked at while idle
//   DataIn, ParityType, StopBits : frame contents, captured on accepted Send
//   DataTx       : registered serial line, idle high
//   Busy         : high while a frame is in progress (state != IDLE)
//   Done         : one-cycle pulse after the last stop bit period
//   state_dbg    : current FSM state, for observation only
//
// Handshake: Send is accepted on any rising edge where the FSM is IDLE
// (including the Done cycle); the frame's first bit appears the next cycle.
// Send is ignored while Busy.
module uart_tx_frame
   import uart_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       BaudTick,
   input  logic       Send,
   input  logic [7:0] DataIn,
   input  logic [1:0] ParityType,
   input  logic       StopBits,
   output logic       DataTx,
   output logic       Busy,
   output logic       Done,
   output state_e     state_dbg
);

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [1:0] par_q, par_d;
   logic       stop2_q, stop2_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       done_q, done_d;
   logic       data_tx_q, data_tx_d;
   logic       parity_bit;

   parity_gen u_parity_gen (
      .data       (data_q),
      .par_type   (par_q),
      .parity_bit (parity_bit)
   );

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (Send) begin
               data_d     = DataIn;
               par_d      = ParityType;
               stop2_d    = StopBits;
               bit_idx_d  = 3'd0;
               stop_cnt_d = 1'b0;
               state_d    = START;
            end
         end
         START: begin
            if (BaudTick) begin
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (BaudTick) begin
               if (bit_idx_q == 3'd7) begin
                  stop_cnt_d = 1'b0;
                  state_d    = has_parity(par_q) ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (BaudTick) begin
               stop_cnt_d = 1'b0;
               state_d    = STOP;
            end
         end
         STOP: begin
            if (BaudTick) begin
               // Second stop period only when two stop bits were captured.
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The line is registered, so it is computed from the next state/index.
      case (state_d)
         START:   data_tx_d = 1'b0;
         DATA:    data_tx_d = data_d[bit_idx_d];
         PARITY:  data_tx_d = parity_bit;
         default: data_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         data_q     <= 8'd0;
         par_q      <= 2'd0;
         stop2_q    <= 1'b0;
         bit_idx_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         done_q     <= 1'b0;
         data_tx_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         done_q     <= done_d;
         data_tx_q  <= data_tx_d;
      end
   end

   assign DataTx    = data_tx_q;
   assign Busy      = (state_q != IDLE);
   assign Done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame -- self-checking bench for uart_tx_frame. Expected line
// bits for each frame are built from the frame rules (start, LSB-first data,
// parity from a ones count, stop bits) and compared every cycle.
module tb_uart_tx_frame;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_tx;
  logic       busy;
  logic       done;
  state_e     state_dbg;

  always #5 clk = ~clk;

  uart_tx_frame dut (
    .Clock      (clk),
    .Reset      (reset),
    .BaudTick   (baud_tick),
    .Send       (send),
    .DataIn     (data_in),
    .ParityType (parity_type),
    .StopBits   (stop_bits),
    .DataTx     (data_tx),
    .Busy       (busy),
    .Done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: the list of line levels, one per bit period, for a frame.
  task automatic build_expected(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    ones = $countones(d);
    if (pt == 2'b01) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    if (pt == 2'b10) exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"},   data_tx, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  // Sends one frame from an idle (or Done) cycle and checks every cycle of it.
  // noisy: scramble Send and frame inputs mid-frame; they must be ignored.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                            input int period, input bit noisy);
    int ticks;
    build_expected(d, pt, sb);
    check_eq("frame_len", exp_q.size(), 10 + (pt == 2'b01 || pt == 2'b10) + sb);
    send = 1'b1; data_in = d; parity_type = pt; stop_bits = sb; baud_tick = 1'b0;
    step();
    send = 1'b0;
    ticks = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      for (int c = 0; c < period; c++) begin
        check_eq("tx_bit", data_tx, exp_q[k]);
        check_eq("busy_frame", busy, 1);
        check_eq("done_early", done, 0);
        if (noisy) begin
          send        = 1'b1;
          data_in     = 8'($urandom);
          parity_type = 2'($urandom);
          stop_bits   = 1'($urandom);
        end
        baud_tick = (c == period - 1);
        if (baud_tick) ticks++;
        step();
        baud_tick = 1'b0;
      end
    end
    check_eq("tick_count", ticks, exp_q.size());
    check_eq("done_pulse", done, 1);
    check_eq("busy_end", busy, 0);
    check_eq("tx_end", data_tx, 1);
    check_eq("state_end", state_dbg, IDLE);
    send = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; baud_tick = 1'b0; send = 1'b0;
    data_in = 8'h00; parity_type = 2'b00; stop_bits = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");
    check_eq("reset_state", state_dbg, IDLE);

    // Ticks and idle time without Send do nothing.
    for (int i = 0; i < 40; i++) begin
      baud_tick = 1'($urandom);
      step();
      check_idle("idle_tick");
    end
    baud_tick = 1'b0;

    // Directed frames.
    send_frame(8'hA5, 2'b01, 1'b0, 16, 1'b0);
    step();
    check_idle("after_a5");
    send_frame(8'h07, 2'b10, 1'b1, 16, 1'b0);
    step();
    send_frame(8'h3C, 2'b00, 1'b0, 16, 1'b0);
    step();
    send_frame(8'h3C, 2'b11, 1'b0, 16, 1'b0);

    // Back-to-back: second Send lands in the Done cycle, inputs noisy mid-frame.
    send_frame(8'h96, 2'b10, 1'b0, 4, 1'b1);
    send_frame(8'h5A, 2'b01, 1'b1, 4, 1'b1);
    step();
    check_idle("after_b2b");

    // Reset during data bit 4.
    build_expected(8'hC3, 2'b01, 1'b1);
    send = 1'b1; data_in = 8'hC3; parity_type = 2'b01; stop_bits = 1'b1;
    step();
    send = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        check_eq("pre_rst_tx", data_tx, exp_q[k]);
        baud_tick = (c == 2);
        step();
        baud_tick = 1'b0;
      end
    end
    check_eq("bit4_tx", data_tx, exp_q[5]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid_reset");
    check_eq("mid_reset_state", state_dbg, IDLE);
    for (int i = 0; i < 40; i++) begin
      baud_tick = (i % 3 == 2);
      step();
      check_idle("post_reset");
    end
    baud_tick = 1'b0;
    send_frame(8'hC3, 2'b01, 1'b1, 3, 1'b0);
    step();

    // Randomized frames, some back-to-back.
    for (int n = 0; n < 25; n++) begin
      send_frame(8'($urandom), 2'($urandom), 1'($urandom),
                 $urandom_range(1, 4), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        step();
        check_idle("rand_gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
